// File: rtl/dbg_scan_ctrl_if.sv
// Readback and display bus between dbg_scan_ctrl and the structures it scans.
// The controller drives the entry address and display frame; the data side returns rd_data.
interface dbg_scan_ctrl_if #(
  parameter int CW = 2,
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [CW-1:0] rd_ch;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] disp_data;
  logic          disp_valid;

  modport master (
    output rd_ch,
    output rd_addr,
    output disp_data,
    output disp_valid,
    input  rd_data
  );

  modport slave (
    input  rd_ch,
    input  rd_addr,
    input  disp_data,
    input  disp_valid,
    output rd_data
  );
endinterface

// File: rtl/dbg_scan_ctrl.sv
// Debug pacing controller: clock divider tick, run/single-step CPU enable and readback scan.
// Optional build macro DBG_TAG_EN tags each data frame with its entry index in the top byte.
module dbg_scan_ctrl #(
  parameter int DIV_W    = 28,
  parameter int FAST_BIT = 24,
  parameter int SLOW_BIT = 27,
  parameter int NCH      = 4,
  parameter int CW       = 2,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel_slow,
  input  logic              step_mode,
  input  logic              step_i,
  input  logic              scan_en,
  input  logic [CW-1:0]     ch_sel,
  input  logic [NCH*AW-1:0] ch_last,
  output logic              tick,
  output logic              cpu_en,
  dbg_scan_ctrl_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_BLANK} state_t;

  localparam logic [DW-1:0] BLANK = '1;

`ifdef DBG_TAG_EN
  function automatic logic [DW-1:0] frame(input logic [DW-1:0] x, input logic [AW-1:0] idx);
    logic [AW+7:0] ext;
    ext = {8'd0, idx};
    return {ext[7:0], x[DW-9:0]};
  endfunction
`else
  function automatic logic [DW-1:0] frame(input logic [DW-1:0] x);
    return x;
  endfunction
`endif

  logic [DIV_W-1:0] div_cnt;
  logic             fast_p0;
  logic             slow_p0;
  logic             div_rise;
  logic             step_p0;
  logic             step_p1;
  logic             step_p2;
  logic             step_rise;

  // Both bits are tracked every cycle so switching sel_slow only sees genuine edges.
  always_comb begin
    div_rise  = sel_slow ? (div_cnt[SLOW_BIT] & ~slow_p0)
                         : (div_cnt[FAST_BIT] & ~fast_p0);
    step_rise = step_p1 & ~step_p2;
  end

  // Stage p0: divider edge history; p0..p1 synchronise step_i, p2 is the edge register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      div_cnt <= '0;
      fast_p0 <= 1'b0;
      slow_p0 <= 1'b0;
      step_p0 <= 1'b0;
      step_p1 <= 1'b0;
      step_p2 <= 1'b0;
      tick    <= 1'b0;
      cpu_en  <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      fast_p0 <= div_cnt[FAST_BIT];
      slow_p0 <= div_cnt[SLOW_BIT];
      step_p0 <= step_i;
      step_p1 <= step_p0;
      step_p2 <= step_p1;
      tick    <= div_rise;
      cpu_en  <= step_mode ? step_rise : div_rise;
    end
  end

  state_t        state_q;
  state_t        state_nxt;
  logic [CW-1:0] rd_ch_q;
  logic [CW-1:0] rd_ch_nxt;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] rd_addr_nxt;
  logic [DW-1:0] disp_p0;
  logic [DW-1:0] disp_nxt;
  logic          vld_p0;
  logic          vld_nxt;
  logic [AW-1:0] last_idx;

  always_comb begin
    last_idx = ch_last[rd_ch_q*AW +: AW];
  end

  always_comb begin
    state_nxt   = state_q;
    rd_ch_nxt   = rd_ch_q;
    rd_addr_nxt = rd_addr_q;
    disp_nxt    = disp_p0;
    vld_nxt     = 1'b0;
    if (ch_sel != rd_ch_q) begin
      // A channel switch restarts the frame and wins over any pending tick.
      rd_ch_nxt   = ch_sel;
      rd_addr_nxt = '0;
      disp_nxt    = BLANK;
      vld_nxt     = 1'b1;
      state_nxt   = scan_en ? S_DATA : S_IDLE;
    end else if (!scan_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_nxt = S_DATA;
        end
        S_DATA: begin
          if (tick) begin
`ifdef DBG_TAG_EN
            disp_nxt = frame(bus.rd_data, rd_addr_q);
`else
            disp_nxt = frame(bus.rd_data);
`endif
            vld_nxt  = 1'b1;
            if (rd_addr_q == last_idx) begin
              state_nxt = S_BLANK;
            end else begin
              rd_addr_nxt = rd_addr_q + 1'b1;
            end
          end
        end
        S_BLANK: begin
          if (tick) begin
            disp_nxt    = BLANK;
            vld_nxt     = 1'b1;
            rd_addr_nxt = '0;
            state_nxt   = S_DATA;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Stage p0: scan state, readback address and display frame
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= S_IDLE;
      rd_ch_q   <= '0;
      rd_addr_q <= '0;
      disp_p0   <= BLANK;
      vld_p0    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rd_ch_q   <= rd_ch_nxt;
      rd_addr_q <= rd_addr_nxt;
      disp_p0   <= disp_nxt;
      vld_p0    <= vld_nxt;
    end
  end

  assign bus.rd_ch      = rd_ch_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.disp_data  = disp_p0;
  assign bus.disp_valid = vld_p0;

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Bench for dbg_scan_ctrl: list-based display model, arithmetic pacing model, frame scoreboard.
module tb_dbg_scan_ctrl;
  localparam int DIV_W    = 8;
  localparam int FAST_BIT = 1;
  localparam int SLOW_BIT = 3;
  localparam int NCH      = 4;
  localparam int CW       = 2;
  localparam int AW       = 5;
  localparam int DW       = 32;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              sel_slow  = 1'b0;
  logic              step_mode = 1'b0;
  logic              step_i    = 1'b0;
  logic              scan_en   = 1'b0;
  logic [CW-1:0]     ch_sel    = '0;
  logic [NCH*AW-1:0] ch_last   = '0;
  logic              tick;
  logic              cpu_en;

  always #5 clk = ~clk;

  dbg_scan_ctrl_if #(.CW(CW), .AW(AW), .DW(DW)) bus ();

  dbg_scan_ctrl #(
    .DIV_W(DIV_W), .FAST_BIT(FAST_BIT), .SLOW_BIT(SLOW_BIT),
    .NCH(NCH), .CW(CW), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rstn(rstn), .sel_slow(sel_slow), .step_mode(step_mode),
    .step_i(step_i), .scan_en(scan_en), .ch_sel(ch_sel), .ch_last(ch_last),
    .tick(tick), .cpu_en(cpu_en), .bus(bus)
  );

  logic [DW-1:0] mem [NCH][32];
  assign bus.rd_data = mem[bus.rd_ch][bus.rd_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int last_of(input int c);
    logic [AW-1:0] f;
    f = ch_last[c*AW +: AW];
    return int'(f);
  endfunction

  function automatic logic [DW-1:0] mframe(input int c, input int pos);
    logic [DW-1:0] d;
    d = mem[c][pos];
`ifdef DBG_TAG_EN
    return ((DW'(pos) & 32'hFF) << 24) | (d & 32'h00FF_FFFF);
`else
    return d;
`endif
  endfunction

  // Reference model: the display walks a cyclic list [entry 0 .. entry L, blank].
  int            cnt = 0;
  int            ecount = 0;
  bit            m_tick = 0;
  bit            m_cpu = 0;
  logic [DW-1:0] m_disp = '1;
  int            m_ch = 0;
  int            m_pos = 0;
  bit            m_active = 0;
  bit            last_samp = 0;
  int            stepq[$];
  logic [DW-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rstn);
      if (rstn) begin
        cnt = 0; m_tick = 0; m_cpu = 0; m_disp = '1;
        m_ch = 0; m_pos = 0; m_active = 0; last_samp = 0;
        stepq.delete(); exp_q.delete();
      end else begin
        int  L;
        bit  tnext;
        bit  spulse;
        ecount++;
        L = last_of(m_ch);
        if (int'(ch_sel) != m_ch) begin
          m_ch = int'(ch_sel); m_pos = 0; m_disp = '1;
          exp_q.push_back('1); m_active = scan_en;
        end else if (!scan_en) begin
          if (m_pos > L) m_pos = L;
          m_active = 0;
        end else if (!m_active) begin
          m_active = 1;
        end else if (m_tick) begin
          if (m_pos <= L) begin
            m_disp = mframe(m_ch, m_pos);
            m_pos++;
          end else begin
            m_disp = '1;
            m_pos = 0;
          end
          exp_q.push_back(m_disp);
        end
        tnext = sel_slow ? (cnt % 16 == 8) : (cnt % 4 == 2);
        cnt = (cnt + 1) % 256;
        spulse = 0;
        if (stepq.size() > 0 && stepq[0] == ecount) begin
          spulse = 1;
          void'(stepq.pop_front());
        end
        if (step_i && !last_samp) stepq.push_back(ecount + 2);
        last_samp = step_i;
        m_cpu  = step_mode ? spulse : tnext;
        m_tick = tnext;
      end
    end
  end

  // Monitor: per-cycle output checks and frame scoreboard on disp_valid.
  initial begin
    forever begin
      int L;
      int eaddr;
      @(negedge clk);
      L = last_of(m_ch);
      eaddr = (m_pos > L) ? L : m_pos;
      chk("tick", tick, m_tick);
      chk("cpu_en", cpu_en, m_cpu);
      chk("rd_ch", bus.rd_ch, m_ch);
      chk("rd_addr", bus.rd_addr, eaddr);
      chk("disp_data", bus.disp_data, m_disp);
      if (bus.disp_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_unexpected: got %h expected no frame at %0t", bus.disp_data, $time);
        end else begin
          chk("frame", bus.disp_data, exp_q.pop_front());
        end
      end
      chk("frame_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    bit found;
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 32; a++)
        mem[c][a] = (c == 2) ? (32'hA0 + a) : $urandom;
    ch_last[0*AW +: AW] = 5'd2;
    ch_last[1*AW +: AW] = 5'd0;
    ch_last[2*AW +: AW] = 5'd3;
    ch_last[3*AW +: AW] = AW'($urandom_range(1, 6));
    #1 rstn = 1'b1;
    cyc(2);
    rstn = 1'b0;

    // Free run, fast then slow pacing
    cyc(40);
    sel_slow = 1'b1;
    cyc(48);

    // Single-step with ticks still running
    sel_slow  = 1'b0;
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_i = 1'b1; cyc(5);
      step_i = 1'b0; cyc(10);
    end

    // Scan channel 2 (entries A0..A3 then blank)
    step_mode = 1'b0;
    scan_en   = 1'b1;
    ch_sel    = 2'd2;
    cyc(80);

    // Channel change coinciding with a tick at address 2
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_tick && m_ch == 2 && m_pos == 2 && m_active) found = 1;
      else cyc(1);
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL chg_wait: got timeout expected tick at addr 2");
    end
    ch_sel = 2'd1;
    @(posedge clk);
    @(negedge clk);
    chk("chg_disp", bus.disp_data, 32'hFFFF_FFFF);
    chk("chg_valid", bus.disp_valid, 1);
    chk("chg_addr", bus.rd_addr, 0);
    chk("chg_ch", bus.rd_ch, 1);
    cyc(30);

    // Randomised mix of all controls
    for (int i = 0; i < 800; i++) begin
      scan_en = ($urandom % 20) != 0;
      if ($urandom % 30 == 0) ch_sel = CW'($urandom % NCH);
      if ($urandom % 50 == 0) sel_slow = ~sel_slow;
      if ($urandom % 60 == 0) step_mode = ~step_mode;
      if ($urandom % 7 == 0) step_i = ~step_i;
      cyc(1);
    end

    // Reset while in S_DATA at address 3
    scan_en = 1'b1; ch_sel = 2'd2; step_mode = 1'b0; sel_slow = 1'b0; step_i = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_ch == 2 && m_pos == 3 && m_active) found = 1;
      else cyc(1);
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL rst_wait: got timeout expected addr 3");
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_disp", bus.disp_data, 32'hFFFF_FFFF);
    chk("rst_valid", bus.disp_valid, 0);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_ch", bus.rd_ch, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cpu_en", cpu_en, 0);
    cyc(1);
    rstn = 1'b0;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dbg_scan_ctrl.md
# dbg_scan_ctrl

- Parametrised debug-and-pacing controller for the single-cycle computer top level.
- Replaces the hard-coded clock divider, the run/single-step control and the per-structure display cycling (register file, ALU, data memory) with one block.
- Generates a one-`clk` CPU enable pulse and steps an index through NCH selectable readback channels, presenting one entry per tick to the seven-segment display path.
- All logic runs on `clk`; no derived clocks.

## Interface
Parameters:
- DIV_W, 28: divider counter width
- FAST_BIT, 24: divider bit used for fast pacing
- SLOW_BIT, 27: divider bit used for slow pacing (must be < DIV_W)
- NCH, 4: number of readback channels (≥2)
- CW, 2: channel select width, = clog2(NCH)
- AW, 5: entry index width
- DW, 32: display data width (≥16)

Ports:
- clk, input, 1: system clock
- rstn, input, 1: reset; asynchronous, active-high (name kept for top-level compatibility)
- sel_slow, input, 1: 1 = pace from SLOW_BIT, 0 = pace from FAST_BIT
- step_mode, input, 1: 1 = single-step, 0 = free run
- step_i, input, 1: asynchronous step button
- scan_en, input, 1: 1 = advance scan on each tick
- ch_sel, input, CW: channel to scan
- ch_last, input, NCH*AW: last valid index per channel; field k = bits [k*AW +: AW]
- rd_data, input, DW: combinational readback of (rd_ch, rd_addr)
- tick, output, 1: one-`clk` pacing pulse
- cpu_en, output, 1: one-`clk` CPU advance enable
- rd_ch, output, CW: registered channel being read
- rd_addr, output, AW: registered entry index
- disp_data, output, DW: frame for the display mux
- disp_valid, output, 1: one-`clk` pulse when disp_data changes

## Operation
Divider:
- div_cnt increments every `clk` and wraps at 2^DIV_W.
- tick pulses on the cycle after the selected bit goes 0→1.
- Toggling sel_slow never produces a double tick; only a registered 0→1 edge of the currently selected bit counts.

CPU enable:
- Run mode: cpu_en = tick.
- Step mode: step_i passes through a 2-flop synchroniser plus an edge register; each synchronised rising edge gives exactly one cpu_en pulse.
- step_i is ignored in run mode. tick is ignored in step mode.

Scan FSM, states S_IDLE, S_DATA, S_BLANK:
- S_IDLE: holds disp_data and rd_addr. Goes to S_DATA when scan_en=1.
- S_DATA, on tick: disp_data ← frame(rd_data), disp_valid=1.
  - If rd_addr == ch_last[rd_ch]: go to S_BLANK.
  - Otherwise: rd_addr += 1.
- S_BLANK, on tick: disp_data ← all ones (frame separator), disp_valid=1, rd_addr ← 0, go to S_DATA.
- scan_en=0 in any state: go to S_IDLE; rd_addr is held. Scanning resumes at the held index.

Boundary cases:
- Channel change (ch_sel ≠ rd_ch) has priority over tick. In that cycle: rd_ch ← ch_sel, rd_addr ← 0, disp_data ← all ones, disp_valid=1, state ← S_DATA (S_IDLE if scan_en=0).
- ch_last = 0: display alternates entry 0 and blank.
- ch_last values above the channel's real depth are the user's responsibility. The block is index-agnostic.
- Reset mid-scan: everything returns to reset values immediately. No partial frame is emitted.

## Timing
Reset values:
- div_cnt=0, tick=0, cpu_en=0, sync flops=0
- rd_ch=0, rd_addr=0, state=S_IDLE
- disp_data=all ones, disp_valid=0

Latencies:
- tick: 1 `clk` after the selected bit's 0→1 transition.
- cpu_en in run mode: same cycle as tick.
- cpu_en in step mode: asserted on the 3rd `clk` edge after step_i is first sampled high.
- disp_data and disp_valid: update on the `clk` edge where tick=1. The frame shows the entry addressed before that edge.
- rd_addr/rd_ch: change on the same edge. rd_data must settle within one `clk`.

## Configuration
- DBG_TAG_EN defined: frame(x) = {idx8, x[DW-9:0]}, where idx8 = rd_addr zero-extended (or truncated) to 8 bits. The display shows the entry number in the top two hex digits.
- DBG_TAG_EN undefined: frame(x) = x.
- The blank frame is all ones in both builds.

## Test plan
Test parameters: DIV_W=8, FAST_BIT=1, SLOW_BIT=3.
- Run mode, sel_slow=0, hold 40 clk → tick every 4 clk, cpu_en identical; switch sel_slow=1 → period 16, no extra pulse at switch.
- step_mode=1, three step_i pulses of 5 clk each, ticks running → exactly 3 cpu_en pulses, each 3 clk after its step_i rise.
- scan_en=1, ch_sel=2, ch_last[2]=3, rd_data=0xA0+addr → disp_data sequence A0,A1,A2,A3,FFFFFFFF,A0.
- Same as previous with DBG_TAG_EN → 000000A0,010000A1,020000A2,030000A3,FFFFFFFF.
- Mid-scan at addr 2, change ch_sel to 1 in the same cycle as a tick → disp_data=FFFFFFFF, rd_addr=0, rd_ch=1, next tick shows channel 1 entry 0.
- Assert rstn while in S_DATA at addr 3 → next cycle all outputs at reset values, disp_data=FFFFFFFF, disp_valid=0.
